// File: rtl/tune_pio_pkg.sv
// rtl/tune_pio_pkg.sv - shared constants and edge helper for the tune PIO blocks
package tune_pio_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Per-bit edge pulse from the current synchronized value and its one-clk-old copy
    function automatic logic [DATA_W-1:0] edge_detect(
        input int                edge_type,
        input logic [DATA_W-1:0] cur,
        input logic [DATA_W-1:0] prev
    );
        logic [DATA_W-1:0] res;
        case (edge_type)
            EDGE_RISE: res = cur & ~prev;
            EDGE_FALL: res = ~cur & prev;
            default:   res = cur ^ prev;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/tune_pio_sync.sv
// rtl/tune_pio_sync.sv - multi-stage synchronizer for an asynchronous input bus
module tune_pio_sync #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    // Shift the raw input through STAGES flops; the last stage is safe to use
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/tune_pio_in.sv
// rtl/tune_pio_in.sv - Avalon-MM input PIO with edge capture and level interrupt
module tune_pio_in
    import tune_pio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0]  sync_q;
    logic [WIDTH-1:0]  prev_q;
    logic [WIDTH-1:0]  edge_det;
    logic [WIDTH-1:0]  irqmask;
    logic [WIDTH-1:0]  edgecapture;
    logic [WIDTH-1:0]  clr;
    logic [DATA_W-1:0] sync_ext;
    logic [DATA_W-1:0] prev_ext;
    logic [DATA_W-1:0] edge_ext;
    logic [DATA_W-1:0] rd_mux;
    logic              wr_en;

    tune_pio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (sync_q)
    );

    assign wr_en = chipselect & ~write_n;

    // Widen to the bus width so the shared helper handles every WIDTH
    always_comb begin
        sync_ext = '0;
        prev_ext = '0;
        sync_ext[WIDTH-1:0] = sync_q;
        prev_ext[WIDTH-1:0] = prev_q;
        edge_ext = edge_detect(EDGE_TYPE, sync_ext, prev_ext);
        edge_det = edge_ext[WIDTH-1:0];
    end

    // Clear mask for edgecapture: only when the CPU writes the capture register
    always_comb begin
        clr = '0;
        if (wr_en && address == ADDR_EDGECAP) begin
            clr = writedata[WIDTH-1:0];
        end
    end

    // One-clk delayed copy of the synchronized input for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= sync_q;
        end
    end

    // Interrupt mask register, written by the CPU
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
        end else if (wr_en && address == ADDR_IRQMASK) begin
            irqmask <= writedata[WIDTH-1:0];
        end
    end

    // Sticky capture; a new edge beats a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecapture <= '0;
        end else begin
            edgecapture <= (edgecapture & ~clr) | edge_det;
        end
    end

    // Registered level interrupt for any unmasked captured edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edgecapture & irqmask);
        end
    end

    // Read mux for the current address, zero-extended to the bus
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = sync_q;
            ADDR_RSVD:    rd_mux = '0;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecapture;
            default:      rd_mux = '0;
        endcase
    end

    // Read data register loads every clk, giving a fixed one-clk read latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_tune_pio_in.sv
// tb/tb_tune_pio_in.sv - scoreboard bench for tune_pio_in (rise, fall and any-edge builds)
module tb_tune_pio_in;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] in_port = '0;

    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tune_pio_in #(.WIDTH(32), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0)
    );

    tune_pio_in #(.WIDTH(8), .EDGE_TYPE(1), .SYNC_STAGES(3)) dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port[7:0]),
        .readdata(rd1), .irq(irq1)
    );

    tune_pio_in #(.WIDTH(32), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2)
    );

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    logic req = 1'b0;
    logic pend = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // A request issued on one negedge is answered by the DUT after the next posedge
    always @(posedge clk) pend <= req;

    // Monitor: pop the oldest expectation whenever a response is due
    always @(negedge clk) begin
        if (pend) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got no entry expected one");
            end else begin
                exp_t e;
                logic [31:0] act;
                e = sbq.pop_front();
                case (e.sel)
                    0:  act = rd0;
                    1:  act = rd1;
                    2:  act = rd2;
                    10: act = {31'd0, irq0};
                    11: act = {31'd0, irq1};
                    default: act = {31'd0, irq2};
                endcase
                check(e.name, act, e.exp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd(input int sel, input logic [1:0] a, input logic [31:0] exp, input string nm);
        address = a;
        chipselect = 1'b1;
        write_n = 1'b1;
        sbq.push_back('{sel, exp, nm});
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chipselect = 1'b0;
    endtask

    task automatic chk_irq(input int sel, input logic exp, input string nm);
        sbq.push_back('{sel + 10, {31'd0, exp}, nm});
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    initial begin
        // reset state
        tick(3);
        check("rst_rd", rd0, 32'h0);
        check("rst_irq", {31'd0, irq0}, 32'h0);
        reset_n = 1'b1;

        // data path and reserved address
        in_port = 32'hA5A5_0F0F;
        tick(4);
        rd(0, 2'd0, 32'hA5A5_0F0F, "data_rd");
        rd(1, 2'd0, 32'h0000_000F, "data_narrow");
        rd(0, 2'd1, 32'h0, "rsvd_rd");
        rd(0, 2'd3, 32'hA5A5_0F0F, "ec_rise_init");
        rd(1, 2'd3, 32'h0, "ec_fall_init");
        rd(2, 2'd3, 32'hA5A5_0F0F, "ec_any_init");
        wr(2'd3, 32'hFFFF_FFFF);
        in_port = 32'h0;
        tick(5);
        rd(0, 2'd3, 32'h0, "ec_rise_fall");
        rd(1, 2'd3, 32'h0000_000F, "ec_fall_fall");
        rd(2, 2'd3, 32'hA5A5_0F0F, "ec_any_fall");
        wr(2'd2, 32'hFFFF_FFFF);
        rd(0, 2'd2, 32'hFFFF_FFFF, "mask_wide");
        rd(1, 2'd2, 32'h0000_00FF, "mask_narrow");
        wr(2'd3, 32'hFFFF_FFFF);
        wr(2'd2, 32'h1);

        // rising capture, irq latency and clear
        in_port = 32'h1;
        tick(2);
        chk_irq(0, 1'b0, "irq_lat_lo");
        chk_irq(0, 1'b1, "irq_lat_hi");
        rd(0, 2'd3, 32'h1, "ec_bit0");
        wr(2'd3, 32'h1);
        chk_irq(0, 1'b0, "irq_clr");
        rd(0, 2'd3, 32'h0, "ec_cleared");

        // masking
        wr(2'd2, 32'h10);
        in_port = 32'h111;
        tick(5);
        rd(0, 2'd3, 32'h110, "ec_mask");
        chk_irq(0, 1'b1, "irq_masked_on");
        wr(2'd2, 32'h0);
        chk_irq(0, 1'b0, "irq_unmask");
        rd(0, 2'd3, 32'h110, "ec_kept");
        rd(0, 2'd2, 32'h0, "mask_zero");
        wr(2'd3, 32'hFFFF_FFFF);

        // clear colliding with a new edge
        in_port = 32'h110;
        tick(5);
        wr(2'd3, 32'hFFFF_FFFF);
        in_port = 32'h113;
        tick(5);
        rd(0, 2'd3, 32'h3, "ec_two");
        in_port = 32'h112;
        tick(5);
        in_port = 32'h113;
        tick(2);
        wr(2'd3, 32'h3);
        rd(0, 2'd3, 32'h1, "ec_set_wins");

        // falling and any edge on bit 2
        in_port = 32'h4;
        tick(6);
        wr(2'd3, 32'hFFFF_FFFF);
        in_port = 32'h0;
        tick(6);
        rd(1, 2'd3, 32'h4, "fall_1to0");
        rd(2, 2'd3, 32'h4, "any_1to0");
        in_port = 32'h4;
        tick(6);
        rd(1, 2'd3, 32'h4, "fall_once");
        rd(2, 2'd3, 32'h4, "any_0to1");
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2, 2'd3, 32'h0, "any_clr");
        in_port = 32'h0;
        tick(6);
        rd(2, 2'd3, 32'h4, "any_reset");

        // reset mid-operation
        wr(2'd2, 32'hFF);
        wr(2'd3, 32'hFFFF_FFFF);
        in_port = 32'hFF;
        tick(6);
        rd(0, 2'd3, 32'hFF, "ec_ff");
        chk_irq(0, 1'b1, "irq_ff");
        in_port = 32'h1;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_irq", {31'd0, irq0}, 32'h0);
        check("arst_rd", rd0, 32'h0);
        check("arst_rd_fall", rd1, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(0, 2'd3, 32'h0, "ec_post_rst");
        rd(0, 2'd2, 32'h0, "mask_post_rst");
        tick(3);
        rd(0, 2'd3, 32'h1, "rst_rise");
        chk_irq(0, 1'b0, "irq_post_rst");

        tick(3);
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
